// File: rtl/vnp4_axis_pkg.sv
// Shared VNP4 AXI-Stream types: default field widths, keep-width helper and the per-beat record.
package vnp4_axis_pkg;

    localparam int VNP4_DATA_W = 512;
    localparam int VNP4_SIZE_W = 16;
    localparam int VNP4_PORT_W = 9;

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int beat_w(input int data_w, input int size_w, input int port_w);
        return data_w + keep_w(data_w) + 2 + size_w + 2 * port_w;
    endfunction

    localparam int VNP4_KEEP_W = keep_w(VNP4_DATA_W);

    typedef struct packed {
        logic [VNP4_DATA_W-1:0] data;
        logic [VNP4_KEEP_W-1:0] keep;
        logic                   last;
        logic                   user_valid;
        logic [VNP4_SIZE_W-1:0] user_size;
        logic [VNP4_PORT_W-1:0] user_ingress_port;
        logic [VNP4_PORT_W-1:0] user_egress_port;
    } vnp4_beat_t;

endpackage

// File: rtl/axis_vnp4_fifo_mem.sv
// Beat storage for axis_vnp4_fifo: one synchronous write port, one asynchronous read port, no reset.
module axis_vnp4_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Pointers never exceed DEPTH-1, so out-of-range addresses are unreachable.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_vnp4_fifo.sv
// First-word fall-through FIFO for the VNP4 AXI-Stream channel (data, keep, last, user sideband).
// Define AXIS_VNP4_FIFO_PKT_CNT_EN to enable the complete-packet counter on pkt_cnt.
module axis_vnp4_fifo
    import vnp4_axis_pkg::*;
#(
    parameter int DATA_W    = VNP4_DATA_W,
    parameter int SIZE_W    = VNP4_SIZE_W,
    parameter int PORT_W    = VNP4_PORT_W,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int KEEP_W    = keep_w(DATA_W),
    parameter int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic              axis_aclk,
    input  logic              axis_rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    input  logic              s_user_valid,
    input  logic [SIZE_W-1:0] s_user_size,
    input  logic [PORT_W-1:0] s_user_ingress_port,
    input  logic [PORT_W-1:0] s_user_egress_port,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    output logic              m_user_valid,
    output logic [SIZE_W-1:0] m_user_size,
    output logic [PORT_W-1:0] m_user_ingress_port,
    output logic [PORT_W-1:0] m_user_egress_port,
    input  logic              m_ready,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full,
    output logic [LVL_W-1:0]  pkt_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    // Same layout as vnp4_beat_t, resized to this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user_valid;
        logic [SIZE_W-1:0] user_size;
        logic [PORT_W-1:0] user_ingress_port;
        logic [PORT_W-1:0] user_egress_port;
    } beat_t;

    beat_t            wr_beat;
    beat_t            rd_beat;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push;
    logic             pop;

    assign s_ready     = (level_q != LVL_W'(DEPTH)) & ~axis_rst;
    assign m_valid     = (level_q != '0);
    assign push        = s_valid & s_ready;
    assign pop         = m_valid & m_ready;
    assign level       = level_q;
    assign almost_full = (level_q >= LVL_W'(AF_THRESH));

    assign wr_beat = '{
        data:              s_data,
        keep:              s_keep,
        last:              s_last,
        user_valid:        s_user_valid,
        user_size:         s_user_size,
        user_ingress_port: s_user_ingress_port,
        user_egress_port:  s_user_egress_port
    };

    axis_vnp4_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(beat_t)),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (axis_aclk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_beat),
        .raddr (rd_ptr_q),
        .rdata (rd_beat)
    );

    assign m_data              = rd_beat.data;
    assign m_keep              = rd_beat.keep;
    assign m_last              = rd_beat.last;
    assign m_user_valid        = rd_beat.user_valid;
    assign m_user_size         = rd_beat.user_size;
    assign m_user_ingress_port = rd_beat.user_ingress_port;
    assign m_user_egress_port  = rd_beat.user_egress_port;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef AXIS_VNP4_FIFO_PKT_CNT_EN
    logic [LVL_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Bounded by level, so no saturation guard is needed.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({push & s_last, pop & m_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule
